// File: rtl/square_pkg.sv
// Shared types and constants for the iterative squarer and its sqrt round-trip partner.
package square_pkg;

  localparam int SQ_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/square_seq.sv
// Iterative shift-add squarer: one partial product per clock, result on the DONE pulse.
// Build option SQUARE_EARLY_EXIT_EN ends CALC once the remaining multiplier bits are all zero.
module square_seq
  import square_pkg::*;
#(
  parameter int W = SQ_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   raiz,
  output logic           busy,
  output logic           endop,
  output logic [2*W-1:0] valor,
  output state_t         dbg_state
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  // Handshake: start is a request that is taken only in IDLE; while busy it is
  // ignored (never queued). endop pulses for one cycle with valor already valid.
  state_t           state_q, state_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   valor_q, valor_d;
  logic [2*W-1:0]   sum;
  logic             last_iter;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      valor_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      valor_q  <= valor_d;
    end
  end

  // The sum includes this iteration's partial product so the final write needs no extra cycle.
  assign sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef SQUARE_EARLY_EXIT_EN
  assign last_iter = (cnt_q == CW'(W - 1)) || ((mplier_q >> 1) == '0);
`else
  assign last_iter = (cnt_q == CW'(W - 1));
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    valor_d  = valor_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{W{1'b0}}, raiz};
          mplier_d = raiz;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          valor_d = sum;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign endop     = (state_q == DONE);
  assign valor     = valor_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_square_seq.sv
// Bench for square_seq: cycle-level reference model (square + expected latency), scoreboard, directed and random phases.
module tb_square_seq;
  import square_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b1;
  logic [7:0]  raiz  = 8'd9;
  logic        busy;
  logic        endop;
  logic [15:0] valor;
  state_t      dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  square_seq #(.W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .raiz      (raiz),
    .busy      (busy),
    .endop     (endop),
    .valor     (valor),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #10 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=%0d req=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // CALC length from the operand alone: W cycles, or the bit length of raiz when early exit is built in.
  function automatic int calc_len(input logic [7:0] r);
    int n;
`ifdef SQUARE_EARLY_EXIT_EN
    n = 1;
    for (int b = 0; b < 8; b++) if (r[b]) n = b + 1;
`else
    n = 8;
`endif
    return n;
  endfunction

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];
  int          m_remain = 0;
  logic [15:0] m_valor  = '0;
  logic [15:0] m_pend   = '0;
  bit          chk_en   = 0;

  always @(posedge clock) begin
    chk_en = 1;
    if (reset) begin
      m_remain = 0;
      m_valor  = '0;
      exp_q.delete();
    end else if (m_remain == 0) begin
      if (start) begin
        m_remain = calc_len(raiz) + 1;
        m_pend   = 16'(raiz) * 16'(raiz);
        exp_q.push_back(m_pend);
      end
    end else begin
      m_remain--;
      if (m_remain == 1) m_valor = m_pend;
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      logic [15:0] e;
      state_t      es;
      es = (m_remain == 0) ? IDLE : (m_remain == 1) ? DONE : CALC;
      check("busy",  32'(busy),  32'(m_remain > 0));
      check("endop", 32'(endop), 32'(m_remain == 1));
      check("valor", 32'(valor), 32'(m_valor));
      check("state", 32'(dbg_state), 32'(es));
      if (endop === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_endop", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_valor", 32'(valor), 32'(e));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Pulses start with r, optionally injects a second start (r2) or a reset n cycles later,
  // and returns CALC cycle count and valor at endop (lat = -1 if no endop within budget).
  task automatic run_op(input logic [7:0] r, input int inject_at, input logic [7:0] r2,
                        input int reset_at, output int lat, output logic [15:0] v, output int n_end);
    int n;
    @(negedge clock);
    start = 1'b1;
    raiz  = r;
    lat   = -1;
    v     = '0;
    n_end = 0;
    n     = 0;
    while (n < 30) begin
      @(negedge clock);
      n++;
      if (n == 1) start = 1'b0;
      if (endop === 1'b1) begin
        n_end++;
        if (lat < 0) begin
          lat = n - 1;
          v   = valor;
        end
      end
      if (reset_at > 0 && n == reset_at + 1) begin
        check("abort_busy",  32'(busy),  32'(0));
        check("abort_valor", 32'(valor), 32'(0));
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
      end
      if (n == inject_at) begin
        start = 1'b1;
        raiz  = r2;
      end
      if (inject_at > 0 && n == inject_at + 1) start = 1'b0;
      if (reset_at > 0 && n == reset_at) reset = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    int          nend;
    logic [15:0] v;
    logic [7:0]  dir_r[4]  = '{8'd4, 8'd255, 8'd0, 8'd128};
    logic [15:0] dir_v[4]  = '{16'd16, 16'd65025, 16'd0, 16'd16384};
`ifdef SQUARE_EARLY_EXIT_EN
    int          dir_l[4]  = '{3, 8, 1, 8};
    int          lat12     = 4;
`else
    int          dir_l[4]  = '{8, 8, 8, 8};
    int          lat12     = 8;
`endif

    // reset held with start asserted: nothing may start
    repeat (3) begin
      @(negedge clock);
      check("rst_valor", 32'(valor), 32'(0));
      check("rst_endop", 32'(endop), 32'(0));
      check("rst_busy",  32'(busy),  32'(0));
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("post_rst_busy", 32'(busy), 32'(0));

    // directed squares with literal values and latencies
    for (int i = 0; i < 4; i++) begin
      run_op(dir_r[i], 0, 8'd0, 0, lat, v, nend);
      check("dir_valor", 32'(v), 32'(dir_v[i]));
      check("dir_lat",   32'(lat), 32'(dir_l[i]));
      check("dir_nend",  32'(nend), 32'(1));
    end

    // second start during CALC is dropped
    run_op(8'd12, 4, 8'd3, 0, lat, v, nend);
    check("ign_valor", 32'(v), 32'(144));
    check("ign_lat",   32'(lat), 32'(lat12));
    check("ign_nend",  32'(nend), 32'(1));

    // reset during CALC aborts with no result
    run_op(8'd200, 0, 8'd0, 5, lat, v, nend);
    check("abort_nend", 32'(nend), 32'(0));
    check("abort_valor_after", 32'(valor), 32'(0));

    // random traffic, with boundary operands and occasional resets
    repeat (900) begin
      @(negedge clock);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0:       raiz = 8'd0;
        1:       raiz = 8'd255;
        2:       raiz = 8'd1;
        default: raiz = 8'($urandom_range(0, 255));
      endcase
      reset = ($urandom_range(0, 149) == 0);
    end
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
